// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one outstanding imem request and presents the fetched word to decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned next_pc raises a sticky fault (code 10) instead of being truncated.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0040_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instrn,
  output logic [5:0]  instrn_opcode,
  output logic [31:0] instrn_pc,
  output logic [31:0] address_plus_4,
  output logic        instrn_valid,
  input  logic        instrn_ready,
  input  logic [31:0] next_pc,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc, pc_nxt, pc_load;
  logic [TW-1:0] timer, timer_nxt;
  logic [1:0]    code_nxt;
  logic          capture;
  logic          misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (next_pc[1:0] != 2'b00);
  assign pc_load    = next_pc;
`else
  assign misaligned = 1'b0;
  assign pc_load    = next_pc & ~32'd3;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    timer_nxt = timer;
    code_nxt  = fault_code;
    capture   = 1'b0;
    unique case (state)
      S_BOOT: state_nxt = S_REQ;
      S_REQ: begin
        if (imem_req_ready) begin
          state_nxt = S_WAIT;
          timer_nxt = '0;
        end
      end
      S_WAIT: begin
        timer_nxt = timer + TW'(1);
        // A response in the final timer cycle still beats the timeout.
        if (imem_rsp_valid) begin
          state_nxt = S_HOLD;
          capture   = 1'b1;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = S_FAULT;
          code_nxt  = 2'b01;
        end
      end
      S_HOLD: begin
        if (instrn_ready) begin
          pc_nxt = pc_load;
          if (misaligned) begin
            state_nxt = S_FAULT;
            code_nxt  = 2'b10;
          end else begin
            state_nxt = S_REQ;
          end
        end
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_BOOT;
      pc         <= RESET_PC;
      timer      <= '0;
      fault_code <= 2'b00;
      instrn     <= '0;
      instrn_pc  <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      timer      <= timer_nxt;
      fault_code <= code_nxt;
      if (capture) begin
        instrn    <= imem_rsp_data;
        instrn_pc <= pc;
      end
    end
  end

  // pc equals instrn_pc throughout HOLD, so pc+4 is the held word's successor
  // while it is valid and RESET_PC+4 straight out of reset.
  assign address_plus_4 = pc + 32'd4;
  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;
  assign instrn_valid   = (state == S_HOLD);
  assign instrn_opcode  = instrn[31:26];
  assign fault          = (state == S_FAULT);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed scoreboard bench for mips_fetch_unit; honours FETCH_ALIGN_CHECK_EN when defined.
module tb_mips_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instrn;
  logic [5:0]  instrn_opcode;
  logic [31:0] instrn_pc;
  logic [31:0] address_plus_4;
  logic        instrn_valid;
  logic        instrn_ready;
  logic [31:0] next_pc;
  logic        fault;
  logic [1:0]  fault_code;

  mips_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instrn         (instrn),
    .instrn_opcode  (instrn_opcode),
    .instrn_pc      (instrn_pc),
    .address_plus_4 (address_plus_4),
    .instrn_valid   (instrn_valid),
    .instrn_ready   (instrn_ready),
    .next_pc        (next_pc),
    .fault          (fault),
    .fault_code     (fault_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  int n_pass  = 0;
  int n_total = 0;
  int acc_cyc = 0;
  int c1, c2, c3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    instrn_ready = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_instrn_valid", instrn_valid, 0);
    chk("rst_instrn", instrn, 0);
    chk("rst_instrn_pc", instrn_pc, 0);
    chk("rst_addr_plus_4", address_plus_4, RESET_PC + 32'd4);
    chk("rst_fault", fault, 0);
    chk("rst_fault_code", fault_code, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  // One full REQ -> WAIT -> HOLD -> accept transaction.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data, input int req_stall,
                           input int rsp_delay, input int hold_stall, input logic [31:0] nxt);
    exp_t e;
    @(negedge clk);
    instrn_ready = 1'b0;
    chk("instrn_valid_drop", instrn_valid, 0);
    for (int i = 0; i < req_stall; i++) begin
      chk("req_valid_stall", imem_req_valid, 1);
      chk("req_addr_stall", imem_req_addr, addr);
      step();
    end
    chk("req_valid", imem_req_valid, 1);
    chk("req_addr", imem_req_addr, addr);
    acc_cyc = cyc;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < rsp_delay; i++) begin
      chk("wait_no_req", imem_req_valid, 0);
      chk("wait_no_fault", fault, 0);
      step();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data = data;
    exp_q.push_back('{instr: data, pc: addr});
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'hDEAD_BEEF;
    chk("hold_valid", instrn_valid, 1);
    if (exp_q.size() == 0) begin
      n_total++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1");
    end else begin
      e = exp_q.pop_front();
      chk("instrn", instrn, e.instr);
      chk("opcode", instrn_opcode, e.instr[31:26]);
      chk("instrn_pc", instrn_pc, e.pc);
      chk("addr_plus_4", address_plus_4, e.pc + 32'd4);
      for (int i = 0; i < hold_stall; i++) begin
        step();
        chk("hold_stable_instrn", instrn, e.instr);
        chk("hold_stable_pc", instrn_pc, e.pc);
        chk("hold_no_req", imem_req_valid, 0);
        chk("hold_valid_stall", instrn_valid, 1);
      end
    end
    instrn_ready = 1'b1;
    next_pc = nxt;
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    instrn_ready = 1'b0;
    next_pc = '0;

    do_reset();

    fetch_one(32'h0040_0000, 32'h8C08_0004, 0, 0, 0, 32'h0040_0004);
    c1 = acc_cyc;
    fetch_one(32'h0040_0004, 32'h2009_0001, 0, 0, 0, 32'h0040_0008);
    c2 = acc_cyc;
    fetch_one(32'h0040_0008, 32'h1109_000E, 0, 0, 0, 32'h0040_0040);
    c3 = acc_cyc;
    chk("throughput_1_2", c2 - c1, 3);
    chk("throughput_2_3", c3 - c2, 3);

    // Branch target, request stall, late response and consumer stall combined.
    fetch_one(32'h0040_0040, 32'h0232_4020, 4, 2, 5, 32'hFFFF_FFFC);
    // Top of address space: address_plus_4 wraps to zero.
    fetch_one(32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 0, 32'h0040_0042);

`ifdef FETCH_ALIGN_CHECK_EN
    @(negedge clk);
    instrn_ready = 1'b0;
    chk("misalign_fault", fault, 1);
    chk("misalign_code", fault_code, 2'b10);
    chk("misalign_req_addr", imem_req_addr, 32'h0040_0042);
    for (int i = 0; i < 3; i++) begin
      chk("misalign_no_req", imem_req_valid, 0);
      chk("misalign_no_instrn", instrn_valid, 0);
      step();
    end
`else
    fetch_one(32'h0040_0040, 32'h8C08_0004, 0, 1, 0, 32'h0040_0004);
    @(negedge clk);
    instrn_ready = 1'b0;
    chk("no_align_fault", fault, 0);
    chk("no_align_code", fault_code, 0);
`endif

    // Response in the last WAIT cycle before timeout still completes.
    do_reset();
    fetch_one(RESET_PC, 32'h3C01_1234, 0, 15, 0, 32'h0040_0004);

    // Reset pulse in the middle of WAIT restarts at RESET_PC.
    @(negedge clk);
    instrn_ready = 1'b0;
    chk("midwait_req_addr", imem_req_addr, 32'h0040_0004);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    do_reset();
    fetch_one(RESET_PC, 32'h8C08_0004, 0, 0, 0, 32'h0040_0004);

    // Timeout: no response for 16 WAIT cycles.
    do_reset();
    @(negedge clk);
    chk("to_req_addr", imem_req_addr, RESET_PC);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to_no_fault_early", fault, 0);
      step();
    end
    chk("to_fault", fault, 1);
    chk("to_code", fault_code, 2'b01);
    chk("to_no_req", imem_req_valid, 0);
    chk("to_no_instrn", instrn_valid, 0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h8C08_0004;
    step();
    imem_rsp_valid = 1'b0;
    step();
    chk("to_late_rsp_fault", fault, 1);
    chk("to_late_rsp_code", fault_code, 2'b01);
    chk("to_late_rsp_instrn_valid", instrn_valid, 0);
    chk("to_late_rsp_instrn", instrn, 32'h8C08_0004 ^ 32'h8C08_0004);

    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
